ib_port_serializer: RTL and testbench

- Parametrised successor to the 3-port RAM write-data shifter.
- Accepts one frame of up to PORT_NUM parallel DATA_W-bit port words through a valid/ready handshake.
- Emits the frame one word per cycle on a single write port, with beat valid, index and last flags.
- Sits between the CNU message-pack stage and the BRAM write interface. Everything is clocked on the rising edge only; no negedge logic.

---
 rtl/ib_port_serializer.sv | 125 ++++++++++++
 tb/tb_ib_port_serializer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_port_serializer.sv
// Frame-to-beat serializer: accepts up to PORT_NUM parallel words per frame
// and emits them one per cycle, port 0 first, on a single write port.
module ib_port_serializer #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned PORT_NUM = 3,
  parameter int unsigned IDX_W    = 2
) (
  input  logic                       ram_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PORT_NUM*DATA_W-1:0] in_ports,
  input  logic [IDX_W-1:0]           in_len,
  output logic [DATA_W-1:0]          port_out,
  output logic                       out_valid,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last
);

  localparam int unsigned BUF_W = PORT_NUM * DATA_W;
  localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(PORT_NUM);
  localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [BUF_W-1:0]     buf_q, buf_d;
  logic [IDX_W-1:0]     len_q, len_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0]    port_q, port_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;

  logic                 accept;
  logic [IDX_W-1:0]     eff_len;
  logic [IDX_W-1:0]     nxt_idx;
  logic [DATA_W-1:0]    nxt_word;

  // Ready only depends on registered state (and reset/enable), never on in_valid.
  assign in_ready = !rst && en && ((state_q == IDLE) || last_q);
  assign accept   = in_valid && in_ready;

  // Zero or oversize lengths mean a full-width frame.
  assign eff_len = ((in_len == '0) || (in_len > MAX_LEN)) ? MAX_LEN : in_len;
  assign nxt_idx = idx_q + ONE;

  // Select the buffered word for the next beat.
  always_comb begin
    nxt_word = '0;
    for (int k = 0; k < int'(PORT_NUM); k++) begin
      if (nxt_idx == IDX_W'(k)) begin
        nxt_word = buf_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    idx_d   = idx_q;
    port_d  = port_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (!en) begin
      state_d = IDLE;
      idx_d   = '0;
      port_d  = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (accept) begin
      state_d = SHIFT;
      buf_d   = in_ports;
      len_d   = eff_len;
      idx_d   = '0;
      port_d  = in_ports[DATA_W-1:0];
      valid_d = 1'b1;
      last_d  = (eff_len == ONE);
    end else if (state_q == SHIFT) begin
      if (last_q) begin
        state_d = IDLE;
        idx_d   = '0;
        port_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        idx_d   = nxt_idx;
        port_d  = nxt_word;
        last_d  = (nxt_idx == (len_q - ONE));
      end
    end
  end

  always_ff @(posedge ram_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      port_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      port_q  <= port_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign port_out  = port_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_ib_port_serializer.sv
// Bench for ib_port_serializer: a queue-of-pending-beats reference model for the
// default configuration plus a directed check of a 4-port, 16-bit instance.
module tb_ib_port_serializer;

  localparam int DW = 32;
  localparam int PN = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PN*DW-1:0] in_ports = '0;
  logic [IW-1:0]    in_len = '0;
  logic [DW-1:0]    port_out;
  logic             out_valid;
  logic [IW-1:0]    out_idx;
  logic             out_last;

  logic             rst_b = 1'b1;
  logic             en_b = 1'b0;
  logic             in_valid_b = 1'b0;
  logic             in_ready_b;
  logic [63:0]      in_ports_b = '0;
  logic [2:0]       in_len_b = '0;
  logic [15:0]      port_out_b;
  logic             out_valid_b;
  logic [2:0]       out_idx_b;
  logic             out_last_b;

  ib_port_serializer #(.DATA_W(DW), .PORT_NUM(PN), .IDX_W(IW)) dut (
    .ram_clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_ports(in_ports), .in_len(in_len), .port_out(port_out),
    .out_valid(out_valid), .out_idx(out_idx), .out_last(out_last)
  );

  ib_port_serializer #(.DATA_W(16), .PORT_NUM(4), .IDX_W(3)) dut_b (
    .ram_clk(clk), .rst(rst_b), .en(en_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_ports(in_ports_b), .in_len(in_len_b), .port_out(port_out_b),
    .out_valid(out_valid_b), .out_idx(out_idx_b), .out_last(out_last_b)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  // Beats still to be shown; element 0 is what port_out should display now.
  beat_t q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic          exp_ready, seen_ready, last_acc;
  logic [DW-1:0] exp_port;
  logic          exp_valid;
  logic [IW-1:0] exp_idx;
  logic          exp_last;

  // Advance one clock edge, predicting ready before it and outputs after it.
  task automatic drive_edge();
    int l;
    @(negedge clk);
    exp_ready  = !rst && en && (q.size() <= 1);
    seen_ready = in_ready;
    last_acc   = in_valid && exp_ready;
    @(posedge clk);
    if (rst || !en) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (last_acc) begin
        l = (in_len == 0 || int'(in_len) > PN) ? PN : int'(in_len);
        for (int k = 0; k < l; k++)
          q.push_back('{in_ports[k*DW +: DW], IW'(k), (k == l - 1)});
      end
    end
    #1;
    if (q.size() > 0) begin
      exp_port = q[0].data; exp_idx = q[0].idx; exp_last = q[0].last; exp_valid = 1'b1;
    end else begin
      exp_port = '0; exp_idx = '0; exp_last = 1'b0; exp_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_b = 1'b1; en = 1'b1; in_valid = 1'b1;
    in_ports = {$urandom, $urandom, $urandom}; in_len = 2'd3;
    for (int i = 0; i < 3; i++) begin
      drive_edge();
      n_cmp++;
      if (seen_ready !== 1'b0) begin
        n_bad++; $display("FAIL reset_ready cyc%0d: got %b want 0", i, seen_ready);
      end
      n_cmp++;
      if ({port_out, out_valid, out_idx, out_last} !== {DW'(0), 1'b0, IW'(0), 1'b0}) begin
        n_bad++; $display("FAIL reset_outputs cyc%0d: got port=%h v=%b idx=%0d last=%b want zeros",
                          i, port_out, out_valid, out_idx, out_last);
      end
    end
    rst = 1'b0; rst_b = 1'b0; in_valid = 1'b0;
    drive_edge();
    n_cmp++;
    if (seen_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: got %b want 1", seen_ready);
    end
  endtask

  task automatic test_single_frame();
    logic [DW-1:0] want [3];
    want[0] = 32'hAAAA0000; want[1] = 32'hBBBB0001; want[2] = 32'hCCCC0002;
    en = 1'b1; in_valid = 1'b1; in_len = 2'd3;
    in_ports = {want[2], want[1], want[0]};
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      in_valid = 1'b0;
      n_cmp++;
      if ({port_out, out_valid, out_idx, out_last} !== {exp_port, exp_valid, exp_idx, exp_last}) begin
        n_bad++; $display("FAIL single_model beat%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", i,
                          port_out, out_valid, out_idx, out_last, exp_port, exp_valid, exp_idx, exp_last);
      end
      n_cmp++;
      if (i < 3 && {port_out, out_valid, out_idx, out_last} !== {want[i], 1'b1, IW'(i), (i == 2)}) begin
        n_bad++; $display("FAIL single_const beat%0d: got %h idx=%0d last=%b want %h idx=%0d",
                          i, port_out, out_idx, out_last, want[i], i);
      end else if (i == 3 && out_valid !== 1'b0) begin
        n_bad++; $display("FAIL single_end: got valid=%b want 0", out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int valid_beats = 0;
    en = 1'b1; in_valid = 1'b1; in_len = 2'd3;
    in_ports = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    for (int i = 0; i < 7; i++) begin
      drive_edge();
      if (last_acc) begin
        accepts++;
        if (accepts == 1) in_ports = {32'h3, 32'h2, 32'h1};
        else in_valid = 1'b0;
      end
      n_cmp++;
      if (seen_ready !== exp_ready) begin
        n_bad++; $display("FAIL b2b_ready cyc%0d: got %b want %b", i, seen_ready, exp_ready);
      end
      n_cmp++;
      if ({port_out, out_valid, out_idx, out_last} !== {exp_port, exp_valid, exp_idx, exp_last}) begin
        n_bad++; $display("FAIL b2b_beat cyc%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", i,
                          port_out, out_valid, out_idx, out_last, exp_port, exp_valid, exp_idx, exp_last);
      end
      if (i < 6 && out_valid === 1'b1) valid_beats++;
    end
    n_cmp++;
    if (valid_beats != 6) begin
      n_bad++; $display("FAIL b2b_continuous: got %0d valid beats want 6", valid_beats);
    end
  endtask

  task automatic test_lengths();
    logic [IW-1:0] lens [3];
    int            nbeats [3];
    int            cnt;
    lens[0] = 2'd1; lens[1] = 2'd0; lens[2] = 2'd2;
    nbeats[0] = 1; nbeats[1] = 3; nbeats[2] = 2;
    en = 1'b1;
    for (int t = 0; t < 3; t++) begin
      in_ports = {32'hDEAD0002, $urandom, $urandom};
      in_len = lens[t]; in_valid = 1'b1;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        drive_edge();
        in_valid = 1'b0;
        n_cmp++;
        if ({port_out, out_valid, out_idx, out_last} !== {exp_port, exp_valid, exp_idx, exp_last}) begin
          n_bad++; $display("FAIL len%0d beat%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", lens[t], i,
                            port_out, out_valid, out_idx, out_last, exp_port, exp_valid, exp_idx, exp_last);
        end
        if (out_valid === 1'b1) cnt++;
        if (out_valid === 1'b1 && port_out === 32'hDEAD0002 && nbeats[t] < 3) begin
          n_bad++; $display("FAIL len%0d_port2_leak: got %h want no port 2", lens[t], port_out);
        end
      end
      n_cmp++;
      if (cnt != nbeats[t]) begin
        n_bad++; $display("FAIL len%0d_count: got %0d beats want %0d", lens[t], cnt, nbeats[t]);
      end
    end
  endtask

  task automatic test_en_drop();
    en = 1'b1; in_valid = 1'b1; in_len = 2'd3;
    in_ports = {32'h33330000, 32'h22220000, 32'h11110000};
    drive_edge();
    in_valid = 1'b0;
    drive_edge();
    n_cmp++;
    if (out_idx !== 2'd1) begin
      n_bad++; $display("FAIL en_drop_setup: got idx=%0d want 1", out_idx);
    end
    en = 1'b0;
    drive_edge();
    n_cmp++;
    if ({port_out, out_valid, out_idx, out_last} !== {DW'(0), 1'b0, IW'(0), 1'b0}) begin
      n_bad++; $display("FAIL en_drop_clear: got %h/%b/%0d/%b want zeros",
                        port_out, out_valid, out_idx, out_last);
    end
    n_cmp++;
    if (seen_ready !== 1'b0) begin
      n_bad++; $display("FAIL en_drop_ready: got %b want 0", seen_ready);
    end
    en = 1'b1; in_valid = 1'b1; in_ports = {32'h66660000, 32'h55550000, 32'h44440000};
    for (int i = 0; i < 4; i++) begin
      drive_edge();
      in_valid = 1'b0;
      n_cmp++;
      if ({port_out, out_valid, out_idx, out_last} !== {exp_port, exp_valid, exp_idx, exp_last}) begin
        n_bad++; $display("FAIL en_restart beat%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", i,
                          port_out, out_valid, out_idx, out_last, exp_port, exp_valid, exp_idx, exp_last);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 15) != 0);
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_len   = IW'($urandom_range(0, 3));
      in_ports = {$urandom, $urandom, $urandom};
      drive_edge();
      n_cmp++;
      if (seen_ready !== exp_ready) begin
        n_bad++; $display("FAIL rand_ready cyc%0d: got %b want %b", i, seen_ready, exp_ready);
      end
      n_cmp++;
      if ({port_out, out_valid, out_idx, out_last} !== {exp_port, exp_valid, exp_idx, exp_last}) begin
        n_bad++; $display("FAIL rand_beat cyc%0d: got %h/%b/%0d/%b want %h/%b/%0d/%b", i,
                          port_out, out_valid, out_idx, out_last, exp_port, exp_valid, exp_idx, exp_last);
      end
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    repeat (4) drive_edge();
  endtask

  task automatic test_param_sweep();
    logic [2:0] lens [2];
    lens[0] = 3'd0; lens[1] = 3'd4;
    en_b = 1'b1;
    in_ports_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in_len_b = lens[0]; in_valid_b = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready_b !== 1'b1) begin
      n_bad++; $display("FAIL sweep_ready: got %b want 1", in_ready_b);
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({port_out_b, out_valid_b, out_idx_b, out_last_b} !== {16'(16'h1111 * (i + 1)), 1'b1, 3'(i), (i == 3)}) begin
        n_bad++; $display("FAIL sweep_beat%0d: got %h/%b/%0d/%b want %h/1/%0d/%b", i,
                          port_out_b, out_valid_b, out_idx_b, out_last_b, 16'(16'h1111 * (i + 1)), i, (i == 3));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (out_valid_b !== 1'b0) begin
      n_bad++; $display("FAIL sweep_end: got valid=%b want 0", out_valid_b);
    end
    in_len_b = lens[1]; in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (out_idx_b !== 3'd1 || port_out_b !== 16'h2222) begin
      n_bad++; $display("FAIL sweep_mid: got idx=%0d port=%h want 1/2222", out_idx_b, port_out_b);
    end
    #1 rst_b = 1'b1;
    #1;
    n_cmp++;
    if ({port_out_b, out_valid_b, out_idx_b, out_last_b} !== {16'h0, 1'b0, 3'd0, 1'b0}) begin
      n_bad++; $display("FAIL sweep_async_rst: got %h/%b/%0d/%b want zeros",
                        port_out_b, out_valid_b, out_idx_b, out_last_b);
    end
    @(negedge clk);
    rst_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_lengths();
    test_en_drop();
    test_random();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
